frame_deserializer_valid_ready: RTL and testbench
=================================================

# frame_deserializer_valid_ready

Serial-to-parallel frame collector: accepts one WIDTH-bit word per valid/ready beat and emits a packed frame of DEPTH words in a single valid/ready beat. It is the inverse of the frame-to-word serializer FIFO. It sits in front of blocks that consume whole sample frames, such as FFT stages that take DEPTH samples at once. Storage is double-buffered (ping-pong), so upstream keeps streaming while downstream holds a completed frame.

## Interface
- WIDTH, 8, bits per word
- DEPTH, 4, words per frame (>= 2)
- clk  in  1  clock, rising edge
- arstn  in  1  reset; asynchronous, active-low
- up_valid  in  1  upstream word valid
- up_ready  out  1  block can accept a word this cycle
- up_data  in  WIDTH  upstream word
- down_valid  out  1  complete frame available
- down_ready  in  1  downstream accepts frame
- down_data  out  [DEPTH-1:0][WIDTH-1:0]  packed frame; element 0 = first word received, element DEPTH-1 = last
- frames_pending  out  2  number of complete frames held (0..2)

## Operation
- State:
  - two banks B0/B1, DEPTH x WIDTH each
  - full[1:0]
  - wr_bank, rd_bank (1 bit each)
  - wr_idx, $clog2(DEPTH) bits, counts 0..DEPTH-1
- Reset values: full=0, wr_bank=0, rd_bank=0, wr_idx=0.
  - Outputs after reset: up_ready=1, down_valid=0, frames_pending=0.
  - Bank storage is not reset; down_data is don't-care while down_valid=0.
- up_ready = ~full[wr_bank]. Push = up_valid & up_ready.
- On push:
  - bank[wr_bank][wr_idx] <= up_data.
  - If wr_idx==DEPTH-1: wr_idx <= 0, full[wr_bank] <= 1, wr_bank toggles.
  - Else wr_idx increments.
- down_valid = full[rd_bank]; down_data = bank[rd_bank]. Pop = down_valid & down_ready.
- On pop: full[rd_bank] <= 0, rd_bank toggles.
- frames_pending = full[0] + full[1], as a 2-bit sum.
- Simultaneous frame completion and pop always target different banks; both updates apply in the same cycle.
- Both banks full (wr_bank==rd_bank): up_ready=0. A word held on up_data is neither written nor counted.
- Frames leave in arrival order; no frame is dropped or duplicated.
- A partial frame (wr_idx>0) is never presented downstream. It waits indefinitely for the remaining words.
- Reset mid-frame or mid-stall discards all partial and complete frames.

## Timing
- up_ready, down_valid, down_data and frames_pending depend only on registered state. There is no combinational path from down_ready to up_ready or from up_valid to down_valid.
- Latency: last word of a frame pushed in cycle N -> down_valid=1 in cycle N+1 with that frame on down_data.
- down_data and down_valid stay stable while down_valid=1 and down_ready=0.
- Throughput: 1 word/cycle sustained when each frame is popped within DEPTH cycles of becoming valid.
- Both banks full and pop in cycle N -> up_ready=1 in cycle N+1. In cycle N itself up_ready is still 0.
- up_ready drops in the cycle after the push that fills the second bank.

## Test plan
- Reset: assert arstn=0 mid-activity -> up_ready=1, down_valid=0, frames_pending=0, immediately and after release.
- Single frame, DEPTH=4, down_ready=1: push 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Required: down_valid=1 exactly one cycle after the 0x44 push.
  - Required: down_data[0..3]=0x11,0x22,0x33,0x44; popped that cycle; frames_pending returns to 0.
- Backpressure, down_ready=0: push 0x01..0x08.
  - Required: after the 8th push, up_ready=0 and frames_pending=2; a held 0x09 is not accepted.
  - Required: down_data=0x01..0x04 stable across the stall.
  - Pulse down_ready for one cycle -> next frame 0x05..0x08 presented, up_ready=1 the following cycle, then 0x09 accepted into element 0.
- Sustained stream: up_valid=1 and down_ready=1 for 64 cycles with an incrementing pattern -> up_ready never 0; 16 frames out in order, each exactly 4 consecutive values.
- Reset mid-frame: push 0xF0,0xF1, then pulse arstn, then push 0xA0..0xA3 -> the only frame out is 0xA0,0xA1,0xA2,0xA3.
- Random stalls: random up_valid/down_ready, 1000 words, scoreboard.
  - Required: in-order, lossless frames.
  - Required: handshake signals stable under stall.
  - Required: frames_pending always equals frames completed minus frames popped.

Source files
------------

// File: rtl/frame_deserializer_valid_ready.sv
// Serial-to-parallel frame collector: gathers DEPTH words of WIDTH bits into
// one packed frame, double-buffered so upstream streams while downstream stalls.
module frame_deserializer_valid_ready #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         arstn,
  input  logic                         up_valid,
  output logic                         up_ready,
  input  logic [WIDTH-1:0]             up_data,
  output logic                         down_valid,
  input  logic                         down_ready,
  output logic [DEPTH-1:0][WIDTH-1:0]  down_data,
  output logic [1:0]                   frames_pending
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] bank0;
  logic [DEPTH-1:0][WIDTH-1:0] bank1;
  logic [1:0]                  full;
  logic [1:0]                  full_nxt;
  logic                        wr_bank;
  logic                        rd_bank;
  logic [IDX_W-1:0]            wr_idx;
  logic                        push;
  logic                        pop;
  logic                        frame_done;

  // All handshake outputs are decoded from registered state only.
  assign up_ready       = ~full[wr_bank];
  assign down_valid     = full[rd_bank];
  assign down_data      = rd_bank ? bank1 : bank0;
  assign frames_pending = {1'b0, full[0]} + {1'b0, full[1]};

  assign push       = up_valid & up_ready;
  assign pop        = down_valid & down_ready;
  assign frame_done = push & (wr_idx == LAST_IDX);

  // Completion and pop always hit different banks, so both can apply at once.
  always_comb begin
    full_nxt = full;
    if (frame_done) full_nxt[wr_bank] = 1'b1;
    if (pop)        full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
    end else begin
      full <= full_nxt;
      if (push) begin
        if (frame_done) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end
      if (pop) rd_bank <= ~rd_bank;
    end
  end

  // Frame storage carries no reset; contents are only observed when full.
  always_ff @(posedge clk) begin
    if (push) begin
      if (wr_bank) bank1[wr_idx] <= up_data;
      else         bank0[wr_idx] <= up_data;
    end
  end

endmodule

// File: tb/tb_frame_deserializer_valid_ready.sv
// Randomized and directed bench for frame_deserializer_valid_ready, checked
// against a queue-of-frames reference model.
module tb_frame_deserializer_valid_ready;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  typedef logic [DEPTH-1:0][WIDTH-1:0] frame_t;

  logic clk;
  logic arstn;
  logic up_valid;
  logic up_ready;
  logic [WIDTH-1:0] up_data;
  logic down_valid;
  logic down_ready;
  frame_t down_data;
  logic [1:0] frames_pending;

  int vectors;
  int miscompares;

  // Reference model: words of the frame in progress, and completed frames in order.
  logic [WIDTH-1:0] part_q[$];
  frame_t frames_q[$];
  int completed;
  int popped;

  frame_deserializer_valid_ready #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .arstn(arstn),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
    .frames_pending(frames_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    part_q.delete();
    frames_q.delete();
    completed = 0;
    popped = 0;
  endtask

  // Advance one clock (negedge to negedge), updating the model from the inputs.
  task automatic tick();
    bit push, pop;
    frame_t f;
    push = up_valid && (frames_q.size() < 2);
    pop  = down_ready && (frames_q.size() > 0);
    @(posedge clk);
    if (pop) begin
      void'(frames_q.pop_front());
      popped++;
    end
    if (push) begin
      part_q.push_back(up_data);
      if (part_q.size() == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) f[i] = part_q[i];
        frames_q.push_back(f);
        part_q.delete();
        completed++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    arstn = 1'b0; up_valid = 1'b0; down_ready = 1'b0; up_data = '0;
    #1;
    vectors++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0 || frames_pending !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_during: up_ready=%b down_valid=%b pending=%0d expected 1 0 0",
               up_ready, down_valid, frames_pending);
    end
    @(negedge clk);
    arstn = 1'b1;
    model_clear();
    @(negedge clk);
    vectors++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0 || frames_pending !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_after: up_ready=%b down_valid=%b pending=%0d expected 1 0 0",
               up_ready, down_valid, frames_pending);
    end
  endtask

  task automatic test_single_frame();
    logic [WIDTH-1:0] words[DEPTH] = '{8'h11, 8'h22, 8'h33, 8'h44};
    frame_t exp;
    for (int i = 0; i < DEPTH; i++) exp[i] = words[i];
    down_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (down_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL single_early_valid: word %0d down_valid=%b expected 0", i, down_valid);
      end
      up_valid = 1'b1; up_data = words[i];
      tick();
    end
    up_valid = 1'b0;
    vectors++;
    if (down_valid !== 1'b1 || down_data !== exp) begin
      miscompares++;
      $display("FAIL single_frame: valid=%b data=%h expected 1 %h", down_valid, down_data, exp);
    end
    tick();
    vectors++;
    if (down_valid !== 1'b0 || frames_pending !== 2'd0) begin
      miscompares++;
      $display("FAIL single_pop: valid=%b pending=%0d expected 0 0", down_valid, frames_pending);
    end
  endtask

  task automatic test_backpressure();
    frame_t f0, f1, f2;
    for (int i = 0; i < DEPTH; i++) begin
      f0[i] = WIDTH'(i + 1);
      f1[i] = WIDTH'(i + 5);
      f2[i] = WIDTH'(i + 9);
    end
    down_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      up_valid = 1'b1; up_data = WIDTH'(i);
      tick();
    end
    up_data = 8'h09;
    for (int s = 0; s < 3; s++) begin
      vectors++;
      if (up_ready !== 1'b0 || frames_pending !== 2'd2 || down_valid !== 1'b1 || down_data !== f0) begin
        miscompares++;
        $display("FAIL bp_stall: cyc %0d up_ready=%b pending=%0d valid=%b data=%h expected 0 2 1 %h",
                 s, up_ready, frames_pending, down_valid, down_data, f0);
      end
      tick();
    end
    down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
    vectors++;
    if (up_ready !== 1'b1 || frames_pending !== 2'd1 || down_data !== f1) begin
      miscompares++;
      $display("FAIL bp_release: up_ready=%b pending=%0d data=%h expected 1 1 %h",
               up_ready, frames_pending, down_data, f1);
    end
    for (int i = 9; i <= 12; i++) begin
      up_valid = 1'b1; up_data = WIDTH'(i);
      tick();
    end
    up_valid = 1'b0;
    down_ready = 1'b1;
    tick();
    vectors++;
    if (down_valid !== 1'b1 || down_data !== f2) begin
      miscompares++;
      $display("FAIL bp_held_word: valid=%b data=%h expected 1 %h", down_valid, down_data, f2);
    end
    tick();
    down_ready = 1'b0;
    vectors++;
    if (frames_pending !== 2'd0) begin
      miscompares++;
      $display("FAIL bp_drain: pending=%0d expected 0", frames_pending);
    end
  endtask

  task automatic test_sustained();
    int start_pops;
    start_pops = popped;
    down_ready = 1'b1;
    up_valid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      up_data = WIDTH'(8'h40 + c);
      vectors++;
      if (up_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL sustained_ready: cyc %0d up_ready=%b expected 1", c, up_ready);
      end
      if (down_valid === 1'b1) begin
        vectors++;
        if (frames_q.size() == 0 || down_data !== frames_q[0]) begin
          miscompares++;
          $display("FAIL sustained_data: cyc %0d data=%h", c, down_data);
        end
        for (int k = 1; k < DEPTH; k++)
          if (down_data[k] !== WIDTH'(down_data[0] + WIDTH'(k))) begin
            miscompares++;
            $display("FAIL sustained_consec: cyc %0d elem %0d got %h expected %h",
                     c, k, down_data[k], WIDTH'(down_data[0] + WIDTH'(k)));
          end
      end
      tick();
    end
    up_valid = 1'b0;
    tick();
    vectors++;
    if (popped - start_pops != 16 || frames_pending !== 2'd0) begin
      miscompares++;
      $display("FAIL sustained_count: frames=%0d pending=%0d expected 16 0",
               popped - start_pops, frames_pending);
    end
    down_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    frame_t exp;
    for (int i = 0; i < DEPTH; i++) exp[i] = WIDTH'(8'hA0 + i);
    down_ready = 1'b0;
    up_valid = 1'b1; up_data = 8'hF0; tick();
    up_data = 8'hF1; tick();
    up_valid = 1'b0;
    arstn = 1'b0;
    #1;
    vectors++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0 || frames_pending !== 2'd0) begin
      miscompares++;
      $display("FAIL midreset_during: up_ready=%b valid=%b pending=%0d expected 1 0 0",
               up_ready, down_valid, frames_pending);
    end
    @(negedge clk);
    arstn = 1'b1;
    model_clear();
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      up_valid = 1'b1; up_data = WIDTH'(8'hA0 + i);
      tick();
    end
    up_valid = 1'b0;
    vectors++;
    if (down_valid !== 1'b1 || down_data !== exp || frames_pending !== 2'd1) begin
      miscompares++;
      $display("FAIL midreset_frame: valid=%b data=%h pending=%0d expected 1 %h 1",
               down_valid, down_data, frames_pending, exp);
    end
    down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
    vectors++;
    if (down_valid !== 1'b0 || frames_pending !== 2'd0) begin
      miscompares++;
      $display("FAIL midreset_only: valid=%b pending=%0d expected 0 0", down_valid, frames_pending);
    end
  endtask

  task automatic test_random_stalls();
    int words, cyc;
    logic prev_stall;
    frame_t prev_data;
    words = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    model_clear();
    while (words < 1000 && cyc < 20000) begin
      up_valid   = ($urandom_range(0, 9) < 7);
      down_ready = ($urandom_range(0, 9) < 6);
      up_data    = WIDTH'($urandom);
      vectors++;
      if (up_ready !== (frames_q.size() < 2) || down_valid !== (frames_q.size() > 0) ||
          frames_pending !== 2'(completed - popped)) begin
        miscompares++;
        $display("FAIL random_hs: cyc %0d up_ready=%b valid=%b pending=%0d expected %b %b %0d",
                 cyc, up_ready, down_valid, frames_pending, frames_q.size() < 2,
                 frames_q.size() > 0, completed - popped);
      end
      if (frames_q.size() > 0 && down_data !== frames_q[0]) begin
        miscompares++;
        $display("FAIL random_data: cyc %0d got %h expected %h", cyc, down_data, frames_q[0]);
      end
      if (prev_stall && (down_valid !== 1'b1 || down_data !== prev_data)) begin
        miscompares++;
        $display("FAIL random_stable: cyc %0d valid=%b data=%h expected 1 %h",
                 cyc, down_valid, down_data, prev_data);
      end
      prev_stall = (down_valid === 1'b1) && !down_ready;
      prev_data  = down_data;
      if (up_valid && frames_q.size() < 2) words++;
      tick();
      cyc++;
    end
    up_valid = 1'b0;
    down_ready = 1'b1;
    for (int c = 0; c < 10 && frames_q.size() > 0; c++) begin
      vectors++;
      if (down_valid !== 1'b1 || down_data !== frames_q[0]) begin
        miscompares++;
        $display("FAIL random_drain: valid=%b data=%h expected 1 %h", down_valid, down_data, frames_q[0]);
      end
      tick();
    end
    down_ready = 1'b0;
    vectors++;
    if (words != 1000 || popped != 250 || frames_pending !== 2'd0 || down_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL random_total: words=%0d frames=%0d pending=%0d valid=%b expected 1000 250 0 0",
               words, popped, frames_pending, down_valid);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_clear();
    test_reset();
    test_single_frame();
    test_backpressure();
    test_sustained();
    test_reset_mid_frame();
    test_random_stalls();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
